// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus scheduler: state encoding, the default
// phase length, the idle level of the active-low strobes and a strobe decoder.
package rtc_bus_pkg;

  localparam int unsigned PHASE_CYC_DEF = 8;

  // Strobes are active-low, so the inactive (idle) level is high.
  localparam logic STROBE_IDLE = 1'b1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] A_SET = 3'd1;
  localparam logic [2:0] A_END = 3'd2;
  localparam logic [2:0] D_RD  = 3'd3;
  localparam logic [2:0] D_WR  = 3'd4;
  localparam logic [2:0] REC   = 3'd5;

  typedef struct packed {
    logic cs;
    logic ad;
    logic wr;
    logic rd;
    logic oe;
  } strobes_t;

  // Strobe levels and buffer enable for each bus state.
  function automatic strobes_t strobes_for(input logic [2:0] st);
    strobes_t s;
    s.cs = STROBE_IDLE;
    s.ad = STROBE_IDLE;
    s.wr = STROBE_IDLE;
    s.rd = STROBE_IDLE;
    s.oe = 1'b0;
    case (st)
      A_SET: begin
        s.cs = ~STROBE_IDLE;
        s.ad = ~STROBE_IDLE;
        s.wr = ~STROBE_IDLE;
        s.oe = 1'b1;
      end
      A_END: begin
        s.oe = 1'b1;
      end
      D_WR: begin
        s.cs = ~STROBE_IDLE;
        s.wr = ~STROBE_IDLE;
        s.oe = 1'b1;
      end
      D_RD: begin
        // The RTC drives the bus here, so our buffer must be off.
        s.cs = ~STROBE_IDLE;
        s.rd = ~STROBE_IDLE;
        s.oe = 1'b0;
      end
      default: begin
        s.oe = 1'b0;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase timer: loads PHASE_CYC-1 on every state change and counts down to
// zero; it parks at zero (never wraps) when not enabled or already expired.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = PHASE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       en_i,
  output logic [7:0] count_o,
  output logic       done_o
);

  localparam logic [7:0] RELOAD = 8'(PHASE_CYC - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: reload on request, else decrement while running and nonzero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (en_i && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == 8'd0);

endmodule

// File: rtl/rtc_bus_sched.sv
// RTC bus scheduler: arbitrates a write and a read requester and runs one
// multiplexed address/data bus cycle (A_SET, A_END, D_RD/D_WR, REC) at a time.
module rtc_bus_sched
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC = PHASE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  input  logic       req_rd,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       CS,
  output logic       AD,
  output logic       WR,
  output logic       RD,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in
);

  logic [2:0] state_q, state_d;
  logic       type_wr_q, type_wr_d;
  logic       last_wr_q, last_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rd_cap_q, rd_cap_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       wr_ack_q, wr_ack_d;
  logic       rd_valid_q, rd_valid_d;
  logic       cs_q, ad_q, wr_q, rd_q, oe_q;
  logic [7:0] bus_out_q, bus_out_d;
  strobes_t   strb_d;

  logic       load;
  logic       grant;
  logic       grant_wr;
  logic       wr_pending;
  logic       rd_pending;
  logic       capture;
  logic       phase_done;
  logic [7:0] phase_cnt;

  rtc_phase_timer #(
    .PHASE_CYC(PHASE_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .en_i   (state_q != IDLE),
    .count_o(phase_cnt),
    .done_o (phase_done)
  );

  // A requester still high during its own ack cycle is the finished request,
  // not a new one, so it is masked for that single cycle.
  assign wr_pending = req_wr && !wr_ack_q;
  assign rd_pending = req_rd && !rd_valid_q;
  assign capture    = (state_q == D_RD) && (phase_cnt == 8'd0);

  // Bus state sequencing, arbitration and completion pulses.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    grant      = 1'b0;
    grant_wr   = 1'b0;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pending || rd_pending) begin
          grant    = 1'b1;
          // On a tie serve the type that was not granted last time.
          grant_wr = wr_pending && (!rd_pending || !last_wr_q);
          load     = 1'b1;
          state_d  = A_SET;
        end else begin
          state_d = IDLE;
        end
      end
      A_SET: begin
        if (phase_done) begin
          load    = 1'b1;
          state_d = A_END;
        end else begin
          state_d = A_SET;
        end
      end
      A_END: begin
        if (phase_done) begin
          load    = 1'b1;
          state_d = type_wr_q ? D_WR : D_RD;
        end else begin
          state_d = A_END;
        end
      end
      D_RD, D_WR: begin
        if (phase_done) begin
          load    = 1'b1;
          state_d = REC;
        end else begin
          state_d = state_q;
        end
      end
      REC: begin
        if (phase_done) begin
          state_d    = IDLE;
          wr_ack_d   = type_wr_q;
          rd_valid_d = !type_wr_q;
        end else begin
          state_d = REC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction latches (taken only at grant) and read data staging.
  always_comb begin
    if (grant) begin
      addr_d    = grant_wr ? wr_addr : rd_addr;
      data_d    = wr_data;
      type_wr_d = grant_wr;
      last_wr_d = grant_wr;
    end else begin
      addr_d    = addr_q;
      data_d    = data_q;
      type_wr_d = type_wr_q;
      last_wr_d = last_wr_q;
    end
    rd_cap_d  = capture ? bus_in : rd_cap_q;
    // rd_data only changes together with the rd_valid pulse.
    rd_data_d = rd_valid_d ? rd_cap_q : rd_data_q;
  end

  // Bus-facing outputs decoded from the next state so they change with it.
  always_comb begin
    strb_d = strobes_for(state_d);
    case (state_d)
      A_SET, A_END: bus_out_d = addr_d;
      D_WR:         bus_out_d = data_d;
      default:      bus_out_d = 8'd0;
    endcase
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      type_wr_q  <= 1'b0;
      last_wr_q  <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      rd_cap_q   <= 8'd0;
      rd_data_q  <= 8'd0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      cs_q       <= STROBE_IDLE;
      ad_q       <= STROBE_IDLE;
      wr_q       <= STROBE_IDLE;
      rd_q       <= STROBE_IDLE;
      oe_q       <= 1'b0;
      bus_out_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      type_wr_q  <= type_wr_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_cap_q   <= rd_cap_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
      cs_q       <= strb_d.cs;
      ad_q       <= strb_d.ad;
      wr_q       <= strb_d.wr;
      rd_q       <= strb_d.rd;
      oe_q       <= strb_d.oe;
      bus_out_q  <= bus_out_d;
    end
  end

  assign CS       = cs_q;
  assign AD       = ad_q;
  assign WR       = wr_q;
  assign RD       = rd_q;
  assign bus_oe   = oe_q;
  assign bus_out  = bus_out_q;
  assign wr_ack   = wr_ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
